// File: rtl/fft_mem_ctrl.sv
// fft_mem_ctrl -- ownership controller for the FFT sample memory.
//
// The sample memory (MEMWIDTH words of WORDWIDTH bits; lower half real,
// upper half imaginary) has a single write path. While IDLE the CPU store
// path owns it. During RUN the FFT accelerator's result stream owns it and
// CPU accesses are stalled. DONE is a one-cycle state that raises the sticky
// done flag before control returns to IDLE.
//
// Optional feature: define FFTCTRL_TIMEOUT_EN to add a RUN watchdog. The
// watchdog aborts to IDLE with err_o=1 once TIMEOUT_CYCLES RUN cycles pass
// without an accepted beat. Without the macro, RUN waits for acc_done_i
// indefinitely.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   cpu_en_i/we_i       CPU access strobe / write enable
//   cpu_addr_i/data_i   CPU word address / write data
//   cpu_stall_o         CPU access refused this cycle (combinational)
//   start_i             start-transform pulse (honoured in IDLE only)
//   busy_o, done_o      transform in progress / sticky completion flag
//   err_o               sticky error flag (bad CPU address, beat overflow,
//                       wrong final beat count, watchdog expiry)
//   acc_start_o         one-cycle start pulse to the accelerator
//   acc_done_i          accelerator finished pulse
//   acc_wvalid_i/wready_o, acc_waddr_i/wdata_i   result beat handshake
//   mem_en_o, mem_we_o  registered CPU write controls
//   accel_mem_en_o      registered accelerator write enable
//   mem_addr_o/data_o   registered write address / data (zero-extended)

module fft_mem_ctrl #(
  parameter int MEMWIDTH       = 64,
  parameter int WORDWIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_en_i,
  input  logic                        cpu_we_i,
  input  logic [31:0]                 cpu_addr_i,
  input  logic [31:0]                 cpu_data_i,
  output logic                        cpu_stall_o,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic                        acc_start_o,
  input  logic                        acc_done_i,
  input  logic                        acc_wvalid_i,
  output logic                        acc_wready_o,
  input  logic [$clog2(MEMWIDTH)-1:0] acc_waddr_i,
  input  logic [WORDWIDTH-1:0]        acc_wdata_i,
  output logic                        mem_en_o,
  output logic                        mem_we_o,
  output logic                        accel_mem_en_o,
  output logic [31:0]                 mem_addr_o,
  output logic [31:0]                 mem_data_o
);

  localparam int AW = $clog2(MEMWIDTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] beat_cnt_next;
  logic          cpu_wr;
  logic          cpu_in_range;
  logic          beat_ok;
  logic          cnt_full;

`ifdef FFTCTRL_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_cnt;
  logic          wd_expire;
`endif

  assign cpu_wr        = cpu_en_i && cpu_we_i;
  assign cpu_in_range  = cpu_addr_i < 32'(MEMWIDTH);
  assign acc_wready_o  = (state == RUN);
  assign busy_o        = (state == RUN);
  // The CPU owns memory only in IDLE; any access elsewhere is refused.
  assign cpu_stall_o   = cpu_en_i && (state != IDLE);
  assign beat_ok       = acc_wvalid_i && acc_wready_o;
  assign cnt_full      = (beat_cnt == CW'(MEMWIDTH));
  // Saturating count including a beat in the current cycle, so a beat that
  // coincides with acc_done_i is counted before the final-count check.
  assign beat_cnt_next = (beat_ok && !cnt_full) ? beat_cnt + 1'b1 : beat_cnt;

`ifdef FFTCTRL_TIMEOUT_EN
  assign wd_expire = !beat_ok && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      beat_cnt       <= '0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      acc_start_o    <= 1'b0;
      mem_en_o       <= 1'b0;
      mem_we_o       <= 1'b0;
      accel_mem_en_o <= 1'b0;
      mem_addr_o     <= '0;
      mem_data_o     <= '0;
`ifdef FFTCTRL_TIMEOUT_EN
      wd_cnt         <= '0;
`endif
    end else begin
      // NOTE: pulse-style outputs get a default low here and are raised only
      // by the branch that accepts a request, so nothing is held over from a
      // previous cycle; later non-blocking assignments override the default.
      acc_start_o    <= 1'b0;
      mem_en_o       <= 1'b0;
      mem_we_o       <= 1'b0;
      accel_mem_en_o <= 1'b0;
      mem_addr_o     <= '0;
      mem_data_o     <= '0;

      case (state)
        IDLE: begin
          if (cpu_wr) begin
            if (cpu_in_range) begin
              mem_en_o   <= 1'b1;
              mem_we_o   <= 1'b1;
              mem_addr_o <= cpu_addr_i;
              mem_data_o <= cpu_data_i;
            end else begin
              err_o <= 1'b1;
            end
          end
          // A same-cycle CPU write is still forwarded above; start then
          // clears the sticky flags for the new transform.
          if (start_i) begin
            state       <= RUN;
            acc_start_o <= 1'b1;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            beat_cnt    <= '0;
`ifdef FFTCTRL_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
          end
        end

        RUN: begin
          if (beat_ok) begin
            if (!cnt_full) begin
              accel_mem_en_o <= 1'b1;
              mem_addr_o     <= 32'(acc_waddr_i);
              mem_data_o     <= 32'(acc_wdata_i);
            end else begin
              // Overflow beats are consumed so the stream cannot deadlock.
              err_o <= 1'b1;
            end
          end
          beat_cnt <= beat_cnt_next;
`ifdef FFTCTRL_TIMEOUT_EN
          wd_cnt <= beat_ok ? '0 : wd_cnt + 1'b1;
`endif
          if (acc_done_i) begin
            state <= DONE;
            if (beat_cnt_next != CW'(MEMWIDTH)) err_o <= 1'b1;
          end
`ifdef FFTCTRL_TIMEOUT_EN
          else if (wd_expire) begin
            state <= IDLE;
            err_o <= 1'b1;
          end
`endif
        end

        DONE: begin
          done_o <= 1'b1;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_mem_ctrl.sv
// tb_fft_mem_ctrl -- directed self-checking bench for fft_mem_ctrl.
// Inputs change 1 ns after the rising edge; outputs are checked at that same
// point, i.e. after the edge that registered them.

module tb_fft_mem_ctrl;

  localparam int MW = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en_i, cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_data_i;
  logic        cpu_stall_o;
  logic        start_i, busy_o, done_o, err_o, acc_start_o;
  logic        acc_done_i, acc_wvalid_i, acc_wready_o;
  logic [5:0]  acc_waddr_i;
  logic [15:0] acc_wdata_i;
  logic        mem_en_o, mem_we_o, accel_mem_en_o;
  logic [31:0] mem_addr_o, mem_data_o;

  int checks = 0;
  int errors = 0;
  int accel_pulses = 0;
  int start_pulses = 0;
  int data_bad = 0;

  fft_mem_ctrl #(.MEMWIDTH(MW), .WORDWIDTH(16), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_en_i(cpu_en_i), .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_stall_o(cpu_stall_o),
    .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .acc_start_o(acc_start_o), .acc_done_i(acc_done_i),
    .acc_wvalid_i(acc_wvalid_i), .acc_wready_o(acc_wready_o),
    .acc_waddr_i(acc_waddr_i), .acc_wdata_i(acc_wdata_i),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .accel_mem_en_o(accel_mem_en_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (accel_mem_en_o) accel_pulses++;
    if (acc_start_o)    start_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got still running, expected finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_en_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_data_i = '0;
    start_i = 0; acc_done_i = 0; acc_wvalid_i = 0;
    acc_waddr_i = '0; acc_wdata_i = '0;
  endtask

  task automatic do_start();
    start_i = 1;
    step();
    start_i = 0;
  endtask

  // Sends n beats at addresses base.., data 16'h5000+index. Every written
  // beat must appear on the memory port with the zero-extended values.
  task automatic run_beats(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      acc_wvalid_i = 1;
      acc_waddr_i  = 6'((base + i) % MW);
      acc_wdata_i  = 16'(16'h5000 + base + i);
      step();
      if (accel_mem_en_o &&
          (mem_addr_o !== 32'((base + i) % MW) ||
           mem_data_o !== 32'(16'h5000 + base + i) ||
           mem_en_o !== 1'b0))
        data_bad++;
    end
    acc_wvalid_i = 0;
  endtask

  task automatic finish_run();
    acc_done_i = 1;
    step();
    acc_done_i = 0;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    step();
    step();
    checks++; if ({mem_en_o, mem_we_o, accel_mem_en_o} !== 3'b000) begin
      errors++; $display("FAIL reset_mem_ctl: got %b, expected 000", {mem_en_o, mem_we_o, accel_mem_en_o}); end
    checks++; if ({mem_addr_o, mem_data_o} !== 64'h0) begin
      errors++; $display("FAIL reset_mem_bus: got %h, expected 0", {mem_addr_o, mem_data_o}); end
    checks++; if ({acc_start_o, acc_wready_o, busy_o, done_o, err_o, cpu_stall_o} !== 6'b0) begin
      errors++; $display("FAIL reset_status: got %b, expected 000000",
                         {acc_start_o, acc_wready_o, busy_o, done_o, err_o, cpu_stall_o}); end
    rst = 1;
    step();
  endtask

  task automatic test_load();
    cpu_en_i = 1; cpu_we_i = 1; cpu_addr_i = 32'd5; cpu_data_i = 32'h1234;
    #1;
    checks++; if (cpu_stall_o !== 1'b0) begin
      errors++; $display("FAIL load_stall: got %b, expected 0", cpu_stall_o); end
    step();
    checks++; if ({mem_en_o, mem_we_o, accel_mem_en_o} !== 3'b110) begin
      errors++; $display("FAIL load_ctl: got %b, expected 110", {mem_en_o, mem_we_o, accel_mem_en_o}); end
    checks++; if (mem_addr_o !== 32'd5 || mem_data_o !== 32'h1234) begin
      errors++; $display("FAIL load_bus: got addr %h data %h, expected 5 1234", mem_addr_o, mem_data_o); end
    cpu_addr_i = 32'd64; cpu_data_i = 32'hDEAD;
    step();
    checks++; if (mem_en_o !== 1'b0 || mem_we_o !== 1'b0) begin
      errors++; $display("FAIL load_oob_dropped: got en %b we %b, expected 0 0", mem_en_o, mem_we_o); end
    checks++; if (err_o !== 1'b1) begin
      errors++; $display("FAIL load_oob_err: got %b, expected 1", err_o); end
    clear_inputs();
    step();
    checks++; if (mem_en_o !== 1'b0) begin
      errors++; $display("FAIL load_idle_quiet: got %b, expected 0", mem_en_o); end
  endtask

  task automatic test_full_run();
    int p0, s0;
    p0 = accel_pulses; s0 = start_pulses; data_bad = 0;
    do_start();
    checks++; if ({acc_start_o, busy_o, acc_wready_o, err_o, done_o} !== 5'b11100) begin
      errors++; $display("FAIL full_start: got %b, expected 11100",
                         {acc_start_o, busy_o, acc_wready_o, err_o, done_o}); end
    run_beats(64, 0);
    checks++; if (acc_start_o !== 1'b0) begin
      errors++; $display("FAIL full_start_pulse_width: got %b, expected 0", acc_start_o); end
    acc_done_i = 1;
    step();
    acc_done_i = 0;
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL full_done_entry: got busy %b done %b, expected 0 0", busy_o, done_o); end
    step();
    checks++; if ({done_o, err_o, busy_o} !== 3'b100) begin
      errors++; $display("FAIL full_flags: got %b, expected 100", {done_o, err_o, busy_o}); end
    checks++; if (accel_pulses - p0 !== 64) begin
      errors++; $display("FAIL full_beats: got %0d, expected 64", accel_pulses - p0); end
    checks++; if (start_pulses - s0 !== 1) begin
      errors++; $display("FAIL full_start_pulses: got %0d, expected 1", start_pulses - s0); end
    checks++; if (data_bad !== 0) begin
      errors++; $display("FAIL full_beat_data: got %0d bad, expected 0", data_bad); end
  endtask

  task automatic test_contention();
    do_start();
    run_beats(30, 0);
    cpu_en_i = 1; cpu_we_i = 1; cpu_addr_i = 32'd7; cpu_data_i = 32'hBEEF;
    #1;
    checks++; if (cpu_stall_o !== 1'b1) begin
      errors++; $display("FAIL cont_stall: got %b, expected 1", cpu_stall_o); end
    step();
    checks++; if (mem_en_o !== 1'b0 || mem_we_o !== 1'b0) begin
      errors++; $display("FAIL cont_blocked: got en %b we %b, expected 0 0", mem_en_o, mem_we_o); end
    cpu_en_i = 0;
    #1;
    checks++; if (cpu_stall_o !== 1'b0) begin
      errors++; $display("FAIL cont_stall_release: got %b, expected 0", cpu_stall_o); end
    run_beats(34, 30);
    finish_run();
    checks++; if ({done_o, err_o} !== 2'b10) begin
      errors++; $display("FAIL cont_run_flags: got %b, expected 10", {done_o, err_o}); end
    cpu_en_i = 1;
    step();
    cpu_en_i = 0;
    checks++; if (mem_en_o !== 1'b1 || mem_addr_o !== 32'd7 || mem_data_o !== 32'hBEEF) begin
      errors++; $display("FAIL cont_retry: got en %b addr %h data %h, expected 1 7 beef",
                         mem_en_o, mem_addr_o, mem_data_o); end
    clear_inputs();
  endtask

  task automatic test_short_run();
    do_start();
    run_beats(10, 0);
    finish_run();
    checks++; if ({done_o, err_o, busy_o} !== 3'b110) begin
      errors++; $display("FAIL short_flags: got %b, expected 110", {done_o, err_o, busy_o}); end
  endtask

  task automatic test_overflow();
    int p0;
    p0 = accel_pulses;
    do_start();
    run_beats(64, 0);
    checks++; if (err_o !== 1'b0) begin
      errors++; $display("FAIL ovf_before: got %b, expected 0", err_o); end
    run_beats(1, 0);
    checks++; if (accel_mem_en_o !== 1'b0 || err_o !== 1'b1) begin
      errors++; $display("FAIL ovf_beat65: got wr %b err %b, expected 0 1", accel_mem_en_o, err_o); end
    finish_run();
    checks++; if ({done_o, err_o} !== 2'b11 || accel_pulses - p0 !== 64) begin
      errors++; $display("FAIL ovf_end: got flags %b writes %0d, expected 11 64",
                         {done_o, err_o}, accel_pulses - p0); end
  endtask

  task automatic test_coincident_done();
    int p0;
    p0 = accel_pulses;
    do_start();
    run_beats(63, 0);
    acc_wvalid_i = 1; acc_waddr_i = 6'd63; acc_wdata_i = 16'h77AA; acc_done_i = 1;
    step();
    clear_inputs();
    checks++; if (accel_mem_en_o !== 1'b1 || mem_data_o !== 32'h77AA || busy_o !== 1'b0) begin
      errors++; $display("FAIL coin_last_beat: got wr %b data %h busy %b, expected 1 77aa 0",
                         accel_mem_en_o, mem_data_o, busy_o); end
    step();
    checks++; if ({done_o, err_o} !== 2'b10 || accel_pulses - p0 !== 64) begin
      errors++; $display("FAIL coin_flags: got flags %b writes %0d, expected 10 64",
                         {done_o, err_o}, accel_pulses - p0); end
  endtask

  task automatic test_reset_mid_run();
    do_start();
    run_beats(20, 0);
    checks++; if (accel_mem_en_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++; $display("FAIL mid_pre: got wr %b busy %b, expected 1 1", accel_mem_en_o, busy_o); end
    acc_wvalid_i = 1; acc_waddr_i = 6'd20; acc_wdata_i = 16'h1111;
    rst = 0;
    step();
    clear_inputs();
    checks++; if ({mem_en_o, mem_we_o, accel_mem_en_o, mem_addr_o, mem_data_o} !== 67'h0) begin
      errors++; $display("FAIL mid_mem_cancel: got %h, expected 0",
                         {mem_en_o, mem_we_o, accel_mem_en_o, mem_addr_o, mem_data_o}); end
    checks++; if ({acc_start_o, acc_wready_o, busy_o, done_o, err_o} !== 5'b0) begin
      errors++; $display("FAIL mid_status: got %b, expected 00000",
                         {acc_start_o, acc_wready_o, busy_o, done_o, err_o}); end
    rst = 1;
    cpu_en_i = 1;
    #1;
    checks++; if (cpu_stall_o !== 1'b0) begin
      errors++; $display("FAIL mid_idle_stall: got %b, expected 0", cpu_stall_o); end
    cpu_en_i = 0;
    step();
  endtask

`ifdef FFTCTRL_TIMEOUT_EN
  task automatic test_timeout();
    do_start();
    for (int i = 0; i < 15; i++) step();
    checks++; if (busy_o !== 1'b1) begin
      errors++; $display("FAIL wd_early: got busy %b, expected 1", busy_o); end
    step();
    checks++; if ({busy_o, err_o, done_o} !== 3'b010) begin
      errors++; $display("FAIL wd_expire: got %b, expected 010", {busy_o, err_o, done_o}); end
    step();
    checks++; if (done_o !== 1'b0) begin
      errors++; $display("FAIL wd_no_done: got %b, expected 0", done_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_full_run();
    test_contention();
    test_short_run();
    test_overflow();
    test_coincident_done();
    test_reset_mid_run();
`ifdef FFTCTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_mem_ctrl.md
# fft_mem_ctrl

Ownership controller for the FFT sample memory (64 × 16-bit flip-flop array; words 0–31 real, 32–63 imaginary). It arbitrates the memory's single write path between the CPU store path and the FFT accelerator's result stream, and sequences each transform: CPU load, accelerator run and writeback, then done. It sits between the core's memory-mapped store logic, the FFT accelerator and the memory instance.

## Interface
Parameters:
- MEMWIDTH, 64, number of memory words; must be a power of two.
- WORDWIDTH, 16, bits per memory word.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with FFTCTRL_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- cpu_en_i  in  1  CPU memory access strobe
- cpu_we_i  in  1  CPU write enable
- cpu_addr_i  in  32  CPU word address
- cpu_data_i  in  32  CPU write data
- cpu_stall_o  out  1  CPU access refused this cycle
- start_i  in  1  start-transform pulse
- busy_o  out  1  transform in progress
- done_o  out  1  sticky completion flag
- err_o  out  1  sticky error flag
- acc_start_o  out  1  one-cycle start pulse to the accelerator
- acc_done_i  in  1  accelerator finished (pulse)
- acc_wvalid_i  in  1  result beat valid
- acc_wready_o  out  1  result beat accepted
- acc_waddr_i  in  $clog2(MEMWIDTH)  result word address
- acc_wdata_i  in  WORDWIDTH  result word
- mem_en_o, mem_we_o, accel_mem_en_o  out  1  memory write controls
- mem_addr_o  out  32  memory address
- mem_data_o  out  32  memory write data

## Operation
- States: IDLE, RUN, DONE. Reset puts the FSM in IDLE.
- IDLE:
  - The CPU owns memory, and cpu_stall_o=0.
  - A CPU write (cpu_en_i && cpu_we_i) with cpu_addr_i < MEMWIDTH is forwarded: mem_en_o=1, mem_we_o=1, address and data copied.
  - A CPU write with cpu_addr_i ≥ MEMWIDTH is dropped and sets err_o.
  - acc_wready_o=0.
  - start_i moves the FSM to RUN, pulses acc_start_o, clears done_o, err_o and the beat counter.
- RUN:
  - busy_o=1 and acc_wready_o=1.
  - A CPU access (cpu_en_i=1) gives cpu_stall_o=1 combinationally and is not forwarded.
  - Each accepted beat (acc_wvalid_i && acc_wready_o) is forwarded: accel_mem_en_o=1, mem_addr_o = zero-extended acc_waddr_i, mem_data_o = zero-extended acc_wdata_i. The beat counter increments.
  - Beats arriving after the counter has reached MEMWIDTH are accepted but not written, and set err_o.
  - On acc_done_i, move to DONE. If the final beat count ≠ MEMWIDTH, also set err_o. A beat in the same cycle as acc_done_i is counted first.
- DONE: lasts one cycle; sets done_o=1 and returns to IDLE.
- start_i outside IDLE is ignored.
- acc_done_i or acc_wvalid_i outside RUN is ignored.
- The beat counter is $clog2(MEMWIDTH)+1 bits wide and saturates at MEMWIDTH.

## Timing
- Reset values: all mem_* outputs 0, acc_start_o=0, acc_wready_o=0, busy_o=0, done_o=0, err_o=0, cpu_stall_o=0.
- mem_* outputs are registered. They reflect an accepted request exactly 1 cycle after acceptance and are 0 otherwise. The memory captures the write on the following edge.
- acc_start_o is high on the cycle after start_i is sampled.
- busy_o rises together with acc_start_o and falls on entry to DONE.
- done_o rises 1 cycle after acc_done_i is sampled.
- A CPU write and start_i in the same IDLE cycle: the write is forwarded, then the FSM enters RUN.
- Reset asserted mid-RUN: the FSM enters IDLE next edge, and any in-flight registered write is cancelled (mem_* = 0).

## Configuration
- FFTCTRL_TIMEOUT_EN defined:
  - A watchdog counts RUN cycles since the last accepted beat (or since entry to RUN).
  - When it reaches TIMEOUT_CYCLES, the FSM goes to IDLE with err_o=1 and done_o=0.
- FFTCTRL_TIMEOUT_EN undefined: no watchdog, and RUN waits for acc_done_i indefinitely.

## Test plan
- Load path: in IDLE, write addr 5, data 0x1234 -> next cycle mem_en_o=1, mem_we_o=1, mem_addr_o=5, mem_data_o=0x1234. Write addr 64 -> nothing forwarded, err_o=1.
- Full transform: start_i, then 64 beats to addresses 0..63, then acc_done_i -> acc_start_o single pulse, 64 accel_mem_en_o cycles, done_o=1, err_o=0, busy_o=0.
- Contention: CPU write during RUN -> cpu_stall_o=1 and no mem_en_o. The same write retried after done -> forwarded.
- Short run: 10 beats then acc_done_i -> done_o=1, err_o=1. A 65th beat in a full run -> accepted, not written, err_o=1.
- Last beat coincides with acc_done_i (beat 64) -> counted, err_o=0.
- Reset mid-RUN after 20 beats -> IDLE; all outputs at reset values next cycle.
- With FFTCTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16: no beats after start -> after 16 cycles, IDLE with err_o=1 and done_o=0.
